// File: rtl/fdce_capture_arbiter.sv
// fdce_capture_arbiter: round-robin loader for one shared CE-gated capture register.
// Define CAPTURE_ARB_PARITY_EN to add the registered Q_PAR output.
module fdce_capture_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int HOLD = 2
) (
    input  logic               C,
    input  logic               CLR_N,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ*DW-1:0] D,
    output logic [NREQ-1:0]    GNT,
    output logic [NREQ-1:0]    ACK,
    output logic [DW-1:0]      Q,
    output logic               Q_VLD,
`ifdef CAPTURE_ARB_PARITY_EN
    output logic               Q_PAR,
`endif
    output logic               BUSY
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int SW = PW + 1;
    localparam int CW = HOLD > 1 ? $clog2(HOLD) : 1;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_DONE} state_t;
    state_t        state;
    logic [PW-1:0] ptr, sel, off, pick;
    logic [PW:0]   sum;
    logic [NREQ-1:0] rr;
    logic [CW-1:0] cnt;
    logic [DW-1:0] word;
    // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
    always_comb begin
        rr = NREQ'({REQ, REQ} >> ptr);
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rr[i]) off = PW'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        pick = sum >= SW'(NREQ) ? PW'(sum - SW'(NREQ)) : PW'(sum);
    end
    always_comb begin
        word = '0;
        for (int i = 0; i < NREQ; i++)
            if (GNT[i]) word = D[i*DW +: DW];
    end
    assign BUSY = state != S_IDLE;
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            state <= S_IDLE;
            ptr   <= '0;
            sel   <= '0;
            cnt   <= '0;
            GNT   <= '0;
            ACK   <= '0;
            Q     <= '0;
            Q_VLD <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (|REQ) begin
                    sel   <= pick;
                    GNT   <= NREQ'(1) << pick;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    Q     <= word;
                    Q_VLD <= 1'b1;
                    cnt   <= CW'(HOLD - 1);
                    state <= S_HOLD;
                end
                S_HOLD: if (cnt == '0) begin
                    ACK   <= GNT;
                    state <= S_DONE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                S_DONE: begin
                    ACK   <= '0;
                    GNT   <= '0;
                    Q_VLD <= 1'b0;
                    ptr   <= sel == PW'(NREQ - 1) ? '0 : sel + 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`ifdef CAPTURE_ARB_PARITY_EN
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) Q_PAR <= 1'b0;
        else if (state == S_LOAD) Q_PAR <= ^word;
    end
`endif
endmodule

// File: tb/tb_fdce_capture_arbiter.sv
// tb_fdce_capture_arbiter: vector table plus scoreboard of expected ACK/Q per transaction.
module tb_fdce_capture_arbiter;
    localparam int NREQ = 4, DW = 8, HOLD = 2;
    logic C = 1'b0, CLR_N = 1'b0;
    logic [NREQ-1:0] REQ = '0;
    logic [NREQ*DW-1:0] D = '0;
    logic [NREQ-1:0] GNT, ACK;
    logic [DW-1:0] Q;
    logic Q_VLD, BUSY;
`ifdef CAPTURE_ARB_PARITY_EN
    logic Q_PAR;
`endif
    int checks = 0, errors = 0, cyc = 0;
    typedef struct { logic [3:0] gnt; logic [7:0] q; } exp_t;
    typedef struct { logic [3:0] req; logic [31:0] d; logic [3:0] gnt; logic [7:0] q; } vec_t;
    exp_t sb[$];
    exp_t e;
    vec_t vt[9];
    logic [3:0] cg[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fdce_capture_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD(HOLD)) dut (
        .C(C),
        .CLR_N(CLR_N),
        .REQ(REQ),
        .D(D),
        .GNT(GNT),
        .ACK(ACK),
        .Q(Q),
        .Q_VLD(Q_VLD),
`ifdef CAPTURE_ARB_PARITY_EN
        .Q_PAR(Q_PAR),
`endif
        .BUSY(BUSY)
    );
    always #5 C = ~C;
    always @(posedge C) cyc++;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge C);
            n++;
        end while (BUSY && n < 50);
        if (BUSY) chk({name, "_timeout"}, 32'(BUSY), 0);
    endtask
    always @(negedge C) begin
        if (CLR_N) begin
            chk("gnt_onehot0", 32'($onehot0(GNT)), 1);
            if (ACK != '0) begin
                if (sb.size() == 0) chk("ack_unexpected", 32'(ACK), 0);
                else begin
                    e = sb.pop_front();
                    chk("ack", 32'(ACK), 32'(e.gnt));
                    chk("ack_gnt", 32'(GNT), 32'(e.gnt));
                    chk("ack_q", 32'(Q), 32'(e.q));
                    chk("ack_qvld", 32'(Q_VLD), 1);
                end
            end
`ifdef CAPTURE_ARB_PARITY_EN
            chk("q_par", 32'(Q_PAR), 32'(^Q));
`endif
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int last, n;
        vt[0] = '{4'b1000, 32'h5A000000, 4'b1000, 8'h5A};
        vt[1] = '{4'b1001, 32'h44000007, 4'b0001, 8'h07};
        vt[2] = '{4'b0001, 32'h00000003, 4'b0001, 8'h03};
        vt[3] = '{4'b0010, 32'h00003C00, 4'b0010, 8'h3C};
        vt[4] = '{4'b0011, 32'h000081FF, 4'b0001, 8'hFF};
        vt[5] = '{4'b1010, 32'h12345678, 4'b0010, 8'h56};
        vt[6] = '{4'b1100, 32'h9ABCDEF0, 4'b0100, 8'hBC};
        vt[7] = '{4'b0111, 32'h01020304, 4'b0001, 8'h04};
        vt[8] = '{4'b0101, 32'hC3E70011, 4'b0100, 8'hE7};
        repeat (2) @(negedge C);
        chk("rst_gnt", 32'(GNT), 0);
        chk("rst_ack", 32'(ACK), 0);
        chk("rst_q", 32'(Q), 0);
        chk("rst_qvld", 32'(Q_VLD), 0);
        chk("rst_busy", 32'(BUSY), 0);
        CLR_N = 1'b1;
        @(negedge C);
        REQ = 4'b0100;
        D = 32'h00A50000;
        sb.push_back('{4'b0100, 8'hA5});
        @(negedge C);
        chk("s_gnt0", 32'(GNT), 32'b0100);
        chk("s_qvld0", 32'(Q_VLD), 0);
        chk("s_busy0", 32'(BUSY), 1);
        REQ = '0;
        @(negedge C);
        chk("s_q1", 32'(Q), 32'hA5);
        chk("s_qvld1", 32'(Q_VLD), 1);
        chk("s_ack1", 32'(ACK), 0);
        @(negedge C);
        chk("s_ack2", 32'(ACK), 0);
        @(negedge C);
        chk("s_ack3", 32'(ACK), 32'b0100);
        @(negedge C);
        chk("s_gnt4", 32'(GNT), 0);
        chk("s_ack4", 32'(ACK), 0);
        chk("s_q4", 32'(Q), 32'hA5);
        chk("s_qvld4", 32'(Q_VLD), 0);
        chk("s_busy4", 32'(BUSY), 0);
        foreach (vt[i]) begin
            REQ = vt[i].req;
            D = vt[i].d;
            sb.push_back('{vt[i].gnt, vt[i].q});
            @(negedge C);
            chk($sformatf("tbl%0d_gnt", i), 32'(GNT), 32'(vt[i].gnt));
            REQ = '0;
            wait_idle($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_q", i), 32'(Q), 32'(vt[i].q));
            chk($sformatf("tbl%0d_qvld", i), 32'(Q_VLD), 0);
        end
        REQ = 4'b0100;
        D = 32'h00FF0000;
        repeat (3) @(posedge C);
        #2;
        CLR_N = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(GNT), 0);
        chk("mid_rst_ack", 32'(ACK), 0);
        chk("mid_rst_q", 32'(Q), 0);
        chk("mid_rst_qvld", 32'(Q_VLD), 0);
        chk("mid_rst_busy", 32'(BUSY), 0);
        sb.delete();
        REQ = 4'b1111;
        D = 32'h40302010;
        for (int k = 0; k < 5; k++) sb.push_back('{cg[k], 8'((k % 4 + 1) * 16)});
        @(negedge C);
        CLR_N = 1'b1;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (GNT == '0 && n < 20) begin
                @(negedge C);
                n++;
            end
            chk($sformatf("cont%0d_gnt", k), 32'(GNT), 32'(cg[k]));
            if (k > 0) chk($sformatf("cont%0d_period", k), cyc - last, 5);
            last = cyc;
            if (k == 4) REQ = '0;
            n = 0;
            while (GNT != '0 && n < 20) begin
                @(negedge C);
                n++;
            end
        end
        wait_idle("cont_end");
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
